// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state type and oversampling constants
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] MID_TICK   = 4'd7;
   localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-frame valid/ready port with per-frame error flags
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 parity_err;
   logic                 frame_err;

   modport master (output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
   modport slave  (input rx_data, rx_valid, parity_err, frame_err, output rx_ready);

endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser with a selectable reset value
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic arst_n,
   input  logic d,
   output logic q
);

   logic m;

   // both stages load the reset value so an idle-high line stays idle through reset
   always_ff @(posedge clk)
      if (!arst_n) {q, m} <= {2{RST_VAL}};
      else         {q, m} <= {m, d};

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with valid/ready output and per-frame error flags
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic      clk,
   input  logic      arst_n,
   input  logic      rx_clk_en,
   input  logic      active,
   input  logic      parity_en,
   input  logic      parity_odd,
   input  logic      rx,
   uart_rx_if.master rxo,
   output logic      overrun,
   output logic      busy
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   uart_rx_state_t       state;
   logic [3:0]           tcnt;
   logic [2:0]           idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr;
   logic                 rx_s;
   logic                 tick_mid;
   logic                 tick_last;
   logic                 done;
   logic                 load;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk    (clk),
      .arst_n (arst_n),
      .d      (rx),
      .q      (rx_s)
   );

   // sample-point strobes, frame completion and whether the completed frame can be stored
   always_comb begin
      tick_mid  = rx_clk_en && tcnt == MID_TICK;
      tick_last = rx_clk_en && tcnt == LAST_TICK;
      done      = active && state == STOP && tick_last;
      load      = done && (!rxo.rx_valid || rxo.rx_ready);
   end

   assign busy = state != IDLE;

   // receive FSM: tick counting, mid-bit sampling and the output holding register
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state          <= IDLE;
         tcnt           <= '0;
         idx            <= '0;
         shreg          <= '0;
         perr           <= 1'b0;
         overrun        <= 1'b0;
         rxo.rx_data    <= '0;
         rxo.rx_valid   <= 1'b0;
         rxo.parity_err <= 1'b0;
         rxo.frame_err  <= 1'b0;
      end else begin
         overrun <= done && !load;
         if (load) begin
            rxo.rx_data    <= shreg;
            rxo.parity_err <= perr;
            rxo.frame_err  <= ~rx_s;
            rxo.rx_valid   <= 1'b1;
         end else if (rxo.rx_valid && rxo.rx_ready) begin
            rxo.rx_valid <= 1'b0;
         end
         if (rx_clk_en) tcnt <= tcnt + 4'd1;
         if (!active) begin
            state <= IDLE;
            tcnt  <= '0;
         end else begin
            case (state)
               IDLE:
                  if (!rx_s) begin
                     state <= START;
                     tcnt  <= '0;
                  end
               START:
                  if (tick_mid) begin
                     state <= rx_s ? IDLE : DATA;
                     tcnt  <= '0;
                     idx   <= '0;
                     perr  <= 1'b0;
                  end
               DATA:
                  if (tick_last) begin
                     shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                     idx   <= idx + 3'd1;
                     if (idx == LAST_IDX) state <= parity_en ? PARITY : STOP;
                  end
               PARITY:
                  if (tick_last) begin
                     perr  <= ^shreg ^ rx_s ^ parity_odd;
                     state <= STOP;
                  end
               STOP:
                  if (tick_last) state <= IDLE;
               default:
                  state <= IDLE;
            endcase
         end
      end
   end

endmodule
